// File: rtl/data_ram_pkg.sv
// Shared types and constants for the dual-port data memory.
// Optional macro DATA_RAM_DP_BYPASS_EN, used in data_ram_array, selects write-first behaviour
// for port B when port B reads the address that port A writes in the same cycle.
package data_ram_pkg;

    typedef enum logic {RAM_INIT, RAM_RUN} ram_state_e;

    localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/data_ram_dp_if.sv
// Bus bundle for data_ram_dp.
// It carries the init control signals, port A (load/store) and port B (read-only peek).
interface data_ram_dp_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  init_req;
    logic                  init_busy;

    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ready;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_ready;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    modport master (
        output init_req, a_req, a_we, a_addr, a_wdata, b_req, b_addr,
        input  init_busy, a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata
    );

    modport slave (
        input  init_req, a_req, a_we, a_addr, a_wdata, b_req, b_addr,
        output init_busy, a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata
    );
endinterface

// File: rtl/data_ram_array.sv
// Storage array with one write port and two registered read ports.
// Macro DATA_RAM_DP_BYPASS_EN: when defined, a port B read that hits the word being written
// in the same cycle returns the new data (write-first). Otherwise it returns the old data.
module data_ram_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  a_re,
    input  logic                  a_rok,
    input  logic [ADDR_WIDTH-1:0] a_raddr,
    input  logic                  b_re,
    input  logic                  b_rok,
    input  logic [ADDR_WIDTH-1:0] b_raddr,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // Storage write; the caller only asserts we for in-range addresses, and the array is never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port A registered read; out-of-range addresses return zero, and the data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
        end else if (a_re) begin
            a_rdata <= a_rok ? mem[a_raddr] : '0;
        end
    end

    // Port B registered read, with the optional write-first forwarding from the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata <= '0;
        end else if (b_re) begin
`ifdef DATA_RAM_DP_BYPASS_EN
            if (we && (waddr == b_raddr)) begin
                b_rdata <= wdata;
            end else begin
                b_rdata <= b_rok ? mem[b_raddr] : '0;
            end
`else
            b_rdata <= b_rok ? mem[b_raddr] : '0;
`endif
        end
    end

endmodule

// File: rtl/data_ram_dp.sv
// Dual-port data memory top level.
// It holds the init sweep FSM, the write-port mux, the ready decode, the range check and the rvalid pipeline.
// Optional macro DATA_RAM_DP_BYPASS_EN (see data_ram_array) selects write-first port B behaviour.
module data_ram_dp
    import data_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MEM_SIZE   = 256,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    data_ram_dp_if.slave  bus
);

    if (MEM_SIZE > (1 << ADDR_WIDTH)) begin : g_size_chk
        $error("data_ram_dp: MEM_SIZE exceeds 2**ADDR_WIDTH");
    end
    if (RAM_READ_LATENCY != 1) begin : g_lat_chk
        $error("data_ram_dp: rvalid pipeline assumes a single-cycle read");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_SIZE - 1);

    ram_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  run, init_we;
    logic                  a_acc, b_acc, a_in_range, b_in_range;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  a_vld_p1, b_vld_p1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RAM_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; init_req is only honoured once the sweep has finished
    always_comb begin
        state_nxt = state;
        case (state)
            RAM_INIT: if (init_cnt == LAST_IDX) state_nxt = RAM_RUN;
            RAM_RUN:  if (bus.init_req)         state_nxt = RAM_INIT;
            default:  state_nxt = RAM_INIT;
        endcase
    end

    // FSM outputs, decoded from the state register only
    always_comb begin
        run     = 1'b0;
        init_we = 1'b0;
        case (state)
            RAM_RUN:  run     = 1'b1;
            default:  init_we = 1'b1;
        endcase
    end

    // Sweep counter walks 0..MEM_SIZE-1 during init and parks at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == RAM_INIT && init_cnt != LAST_IDX) begin
            init_cnt <= init_cnt + 1'b1;
        end else begin
            init_cnt <= '0;
        end
    end

    assign bus.init_busy = init_we;
    assign bus.a_ready   = run;
    assign bus.b_ready   = run;

    assign a_acc      = bus.a_req && run;
    assign b_acc      = bus.b_req && run;
    assign a_in_range = 32'(bus.a_addr) < MEM_SIZE;
    assign b_in_range = 32'(bus.b_addr) < MEM_SIZE;

    // The sweep owns the write port during init; otherwise in-range port A writes use it
    always_comb begin
        we    = 1'b0;
        waddr = bus.a_addr;
        wdata = bus.a_wdata;
        if (init_we) begin
            we    = 1'b1;
            waddr = init_cnt;
            wdata = INIT_VALUE;
        end else if (a_acc && bus.a_we && a_in_range) begin
            we    = 1'b1;
        end
    end

    // ---- stage p0 -> p1: read issue to read-data valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_p1 <= 1'b0;
            b_vld_p1 <= 1'b0;
        end else begin
            a_vld_p1 <= a_acc && !bus.a_we;
            b_vld_p1 <= b_acc;
        end
    end

    assign bus.a_rvalid = a_vld_p1;
    assign bus.b_rvalid = b_vld_p1;

    data_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .a_re    (a_acc && !bus.a_we),
        .a_rok   (a_in_range),
        .a_raddr (bus.a_addr),
        .b_re    (b_acc),
        .b_rok   (b_in_range),
        .b_raddr (bus.b_addr),
        .a_rdata (bus.a_rdata),
        .b_rdata (bus.b_rdata)
    );

endmodule

// File: tb/tb_data_ram_dp.sv
// Testbench for data_ram_dp.
// Scoreboard queues are filled at request time, and per-port monitors pop them when rvalid is seen.
// It covers a 256-word instance and a 200-word instance for the out-of-range cases.
module tb_data_ram_dp;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qs[$];

    data_ram_dp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m();
    data_ram_dp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) s();

    data_ram_dp #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_SIZE(256), .INIT_VALUE(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    data_ram_dp #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_SIZE(200), .INIT_VALUE(8'h00)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Port A monitor for the 256-word instance
    always @(negedge clk) begin
        if (m.a_rvalid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_rvalid_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rdata", {24'd0, m.a_rdata}, {24'd0, e.d});
                chk("a_rvalid_cycle", cyc, e.c);
            end
        end
    end

    // Port B monitor for the 256-word instance
    always @(negedge clk) begin
        if (m.b_rvalid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_rvalid_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rdata", {24'd0, m.b_rdata}, {24'd0, e.d});
                chk("b_rvalid_cycle", cyc, e.c);
            end
        end
    end

    // Port A monitor for the 200-word instance
    always @(negedge clk) begin
        if (s.a_rvalid === 1'b1) begin
            if (qs.size() == 0) begin
                chk("s_rvalid_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = qs.pop_front();
                chk("s_rdata", {24'd0, s.a_rdata}, {24'd0, e.d});
                chk("s_rvalid_cycle", cyc, e.c);
            end
        end
    end

    task automatic a_write(input logic [7:0] addr, input logic [7:0] d);
        m.a_req = 1'b1; m.a_we = 1'b1; m.a_addr = addr; m.a_wdata = d;
        @(negedge clk);
        m.a_req = 1'b0; m.a_we = 1'b0;
    endtask

    task automatic a_read(input logic [7:0] addr, input logic [7:0] exp_d);
        m.a_req = 1'b1; m.a_we = 1'b0; m.a_addr = addr;
        qa.push_back('{exp_d, cyc + 1});
        @(negedge clk);
        m.a_req = 1'b0;
    endtask

    task automatic b_read(input logic [7:0] addr, input logic [7:0] exp_d);
        m.b_req = 1'b1; m.b_addr = addr;
        qb.push_back('{exp_d, cyc + 1});
        @(negedge clk);
        m.b_req = 1'b0;
    endtask

    task automatic s_write(input logic [7:0] addr, input logic [7:0] d);
        s.a_req = 1'b1; s.a_we = 1'b1; s.a_addr = addr; s.a_wdata = d;
        @(negedge clk);
        s.a_req = 1'b0; s.a_we = 1'b0;
    endtask

    task automatic s_read(input logic [7:0] addr, input logic [7:0] exp_d);
        s.a_req = 1'b1; s.a_we = 1'b0; s.a_addr = addr;
        qs.push_back('{exp_d, cyc + 1});
        @(negedge clk);
        s.a_req = 1'b0;
    endtask

    // Counts sweep cycles from the current negedge; optionally pulses init_req at cycle mid
    task automatic count_busy(input string name, input int mid);
        int n;
        logic rdy_bad;
        n = 0;
        rdy_bad = 1'b0;
        while (m.init_busy === 1'b1 && n < 1000) begin
            if (m.a_ready !== 1'b0 || m.b_ready !== 1'b0) rdy_bad = 1'b1;
            m.init_req = (n == mid);
            n++;
            @(negedge clk);
        end
        m.init_req = 1'b0;
        chk({name, "_busy_cycles"}, n, 256);
        chk({name, "_ready_low_while_busy"}, {31'd0, rdy_bad}, 0);
        chk({name, "_ready_after_sweep"}, {31'd0, m.a_ready & m.b_ready}, 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_init_busy"}, {31'd0, m.init_busy}, 1);
        chk({name, "_a_ready"},   {31'd0, m.a_ready},   0);
        chk({name, "_b_ready"},   {31'd0, m.b_ready},   0);
        chk({name, "_a_rvalid"},  {31'd0, m.a_rvalid},  0);
        chk({name, "_b_rvalid"},  {31'd0, m.b_rvalid},  0);
        chk({name, "_a_rdata"},   {24'd0, m.a_rdata},   0);
        chk({name, "_b_rdata"},   {24'd0, m.b_rdata},   0);
    endtask

    initial begin
        logic [7:0] fill [5];
        logic [7:0] byp_exp;
        fill = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h30};
`ifdef DATA_RAM_DP_BYPASS_EN
        byp_exp = 8'h3C;
`else
        byp_exp = 8'h00;
`endif
        m.init_req = 0; m.a_req = 0; m.a_we = 0; m.a_addr = 0; m.a_wdata = 0; m.b_req = 0; m.b_addr = 0;
        s.init_req = 0; s.a_req = 0; s.a_we = 0; s.a_addr = 0; s.a_wdata = 0; s.b_req = 0; s.b_addr = 0;

        // Reset state and the power-up sweep
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy("powerup", -1);

        // Freshly cleared words seen through port B, back to back
        b_read(8'h00, 8'h00);
        b_read(8'h80, 8'h00);
        b_read(8'hFF, 8'h00);
        repeat (2) @(negedge clk);

        // 200-word instance: writes past the end are dropped, reads past the end return zero
        chk("s_ready", {31'd0, s.a_ready}, 1);
        s_write(8'h70, 8'h11);
        s_write(8'hF0, 8'h77);
        s_read(8'hF0, 8'h00);
        s_read(8'h70, 8'h11);
        repeat (2) @(negedge clk);

        // Write then read, then check that rdata holds while rvalid stays low
        a_write(8'h10, 8'hA5);
        a_read(8'h10, 8'hA5);
        repeat (3) begin
            @(negedge clk);
            chk("a_rvalid_idle", {31'd0, m.a_rvalid}, 0);
            chk("a_rdata_hold", {24'd0, m.a_rdata}, 32'hA5);
        end

        // Port A write colliding with a port B read of the same word
        m.a_req = 1; m.a_we = 1; m.a_addr = 8'h20; m.a_wdata = 8'h3C;
        m.b_req = 1; m.b_addr = 8'h20;
        qb.push_back('{byp_exp, cyc + 1});
        @(negedge clk);
        m.a_req = 0; m.a_we = 0; m.b_req = 0;

        // Both ports read the same word in one cycle
        m.a_req = 1; m.a_addr = 8'h20; m.b_req = 1; m.b_addr = 8'h20;
        qa.push_back('{8'h3C, cyc + 1});
        qb.push_back('{8'h3C, cyc + 1});
        @(negedge clk);
        m.a_req = 0; m.b_req = 0;
        repeat (2) @(negedge clk);

        // Fill some words with 0xFF, then re-init together with an accepted read
        foreach (fill[i]) a_write(fill[i], 8'hFF);
        a_read(8'h80, 8'hFF);
        m.init_req = 1; m.a_req = 1; m.a_addr = 8'h01;
        qa.push_back('{8'hFF, cyc + 1});
        @(negedge clk);
        m.init_req = 0; m.a_req = 0;
        chk("ready_drop_after_init_req", {31'd0, m.a_ready}, 0);
        count_busy("reinit", 100);
        foreach (fill[i]) begin
            a_read(fill[i], 8'h00);
            b_read(fill[i], 8'h00);
        end
        chk("a_rdata_after_reinit", {24'd0, m.a_rdata}, 0);

        // Load nonzero read data, then reset in the middle of a sweep
        a_write(8'h30, 8'h5A);
        a_read(8'h30, 8'h5A);
        b_read(8'h30, 8'h5A);
        @(negedge clk);
        m.init_req = 1;
        @(negedge clk);
        m.init_req = 0;
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midsweep_rst");
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("after_rst", -1);

        // A read whose rvalid is cancelled by reset before it can be observed
        a_write(8'h30, 8'h5A);
        a_read(8'h30, 8'h5A);
        @(negedge clk);
        m.a_req = 1; m.a_addr = 8'h30;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("cancel_rst");
        m.a_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qs_drained", qs.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
